// File: rtl/chain_score_select_if.sv
// Pair-score stream in, per-anchor chaining result out, plus the sticky overflow flag.
// Latency: none (signal bundle only).
// Backpressure: s_ready is driven by the stage; m_ready is driven by the result consumer.
//
// Ports:
//   s_*           pair-score beat from computeScore (valid/ready, s_last closes an anchor)
//   m_*           per-anchor result toward the f-buffer / backtrack writer (valid/ready)
//   err_overflow  sticky: an anchor carried more beats than the stage is sized for
interface chain_score_select_if #(
    parameter int DW = 32,
    parameter int IW = 16
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_score;
    logic [DW-1:0] s_pred_f;
    logic [IW-1:0] s_pred_idx;
    logic          s_skip;
    logic          s_last;
    logic [DW-1:0] s_anchor_w;

    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_f;
    logic [IW-1:0] m_pred_idx;
    logic          m_pred_none;
    logic [IW-1:0] m_pred_cnt;

    logic          err_overflow;

    // Producer of beats / consumer of results (testbench or neighbouring stages).
    modport master (
        output s_valid, s_score, s_pred_f, s_pred_idx, s_skip, s_last, s_anchor_w,
        input  s_ready,
        input  m_valid, m_f, m_pred_idx, m_pred_none, m_pred_cnt,
        output m_ready,
        input  err_overflow
    );

    // The reduction stage itself.
    modport slave (
        input  s_valid, s_score, s_pred_f, s_pred_idx, s_skip, s_last, s_anchor_w,
        output s_ready,
        output m_valid, m_f, m_pred_idx, m_pred_none, m_pred_cnt,
        input  m_ready,
        output err_overflow
    );
endinterface

// File: rtl/chain_score_select.sv
// Reduce one anchor's pair-score beats to f[i] = max(W_i, f[j]+score(j,i)) plus the winning j.
// Latency: m_valid rises the cycle after the s_last beat is accepted.
// Backpressure: s_ready drops while a result is held; one bubble per anchor, no overlap.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus (slave)  s_* beat stream in, m_* result out, err_overflow sticky flag
module chain_score_select #(
    parameter int DW       = 32,
    parameter int IW       = 16,
    parameter int MAX_PRED = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    chain_score_select_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    // Beat counter only needs to reach MAX_PRED+1 (first illegal beat), then it parks.
    localparam int          BW        = $clog2(MAX_PRED + 2);
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_PRED);
    localparam logic [BW-1:0] BEAT_SAT = BW'(MAX_PRED + 1);

    localparam logic [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    state_t        r_state;
    state_t        w_state_nxt;

    logic [DW-1:0] r_best;
    logic [IW-1:0] r_idx;
    logic          r_none;
    logic [IW-1:0] r_cnt;
    logic [BW-1:0] r_beats;
    logic          r_err;

    logic          w_s_ready;
    logic          w_m_valid;
    logic          w_acc;
    logic          w_first;

    logic [DW:0]   w_sum;
    logic [DW-1:0] w_cand;

    logic [DW-1:0] w_base_best;
    logic [IW-1:0] w_base_idx;
    logic          w_base_none;
    logic [IW-1:0] w_base_cnt;
    logic          w_better;

    logic [DW-1:0] w_best_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_none_nxt;
    logic [IW-1:0] w_cnt_nxt;
    logic [BW-1:0] w_beats_nxt;

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_s_ready   = 1'b0;
        w_m_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_state_nxt = bus.s_last ? ST_OUTPUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_s_ready = 1'b1;
                if (bus.s_valid && bus.s_last) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_m_valid = 1'b1;
                if (bus.m_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_acc   = bus.s_valid && w_s_ready;
    assign w_first = (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Candidate f[j]+score, one guard bit, clamped to the signed range.
    // Overflow shows up as the guard bit disagreeing with the sign bit.
    // ------------------------------------------------------------------
    assign w_sum = {bus.s_pred_f[DW-1], bus.s_pred_f} + {bus.s_score[DW-1], bus.s_score};

    always_comb begin
        w_cand = w_sum[DW-1:0];
        if (w_sum[DW] != w_sum[DW-1]) begin
            w_cand = w_sum[DW] ? S_MIN : S_MAX;
        end
    end

    // ------------------------------------------------------------------
    // Reduction. On the first beat the running state is replaced by the
    // anchor's own W_i before the beat is compared, so a single-beat anchor
    // still sees W_i as the incumbent.
    // ------------------------------------------------------------------
    always_comb begin
        w_base_best = w_first ? bus.s_anchor_w : r_best;
        w_base_idx  = w_first ? '0 : r_idx;
        w_base_none = w_first ? 1'b1 : r_none;
        w_base_cnt  = w_first ? '0 : r_cnt;

        // Strict compare: ties keep the earlier winner (or W_i).
        w_better = !bus.s_skip && ($signed(w_cand) > $signed(w_base_best));

        w_best_nxt = w_better ? w_cand : w_base_best;
        w_idx_nxt  = w_better ? bus.s_pred_idx : w_base_idx;
        w_none_nxt = w_better ? 1'b0 : w_base_none;

        w_cnt_nxt = w_base_cnt;
        if (!bus.s_skip && (w_base_cnt != {IW{1'b1}})) begin
            w_cnt_nxt = w_base_cnt + IW'(1);
        end

        // Skip beats count toward the overflow limit as well.
        if (w_first) begin
            w_beats_nxt = BW'(1);
        end else if (r_beats == BEAT_SAT) begin
            w_beats_nxt = r_beats;
        end else begin
            w_beats_nxt = r_beats + BW'(1);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_best  <= '0;
            r_idx   <= '0;
            r_none  <= 1'b1;
            r_cnt   <= '0;
            r_beats <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc) begin
                r_best  <= w_best_nxt;
                r_idx   <= w_idx_nxt;
                r_none  <= w_none_nxt;
                r_cnt   <= w_cnt_nxt;
                r_beats <= w_beats_nxt;
                if (w_beats_nxt > BEAT_MAX) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.s_ready      = w_s_ready;
    assign bus.m_valid      = w_m_valid;
    assign bus.m_f          = r_best;
    assign bus.m_pred_idx   = r_idx;
    assign bus.m_pred_none  = r_none;
    assign bus.m_pred_cnt   = r_cnt;
    assign bus.err_overflow = r_err;

endmodule

// File: tb/tb_chain_score_select.sv
// Self-checking bench for chain_score_select: scoreboarded anchors, backpressure, overflow, reset.
// Latency: expects m_valid one cycle after the s_last beat is accepted.
// Backpressure: m_ready is stalled by the bench for several cycles in one scenario.
module tb_chain_score_select;

    localparam int DW       = 32;
    localparam int IW       = 16;
    localparam int MAX_PRED = 64;
    localparam longint SMAX = (64'sd1 <<< (DW-1)) - 64'sd1;
    localparam longint SMIN = -(64'sd1 <<< (DW-1));

    typedef struct packed {
        logic [DW-1:0] f;
        logic [DW-1:0] s;
        logic [IW-1:0] j;
        logic          skip;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] f;
        logic [IW-1:0] idx;
        logic          none;
        logic [IW-1:0] cnt;
    } res_t;

    logic clk;
    logic reset;

    chain_score_select_if #(.DW(DW), .IW(IW)) bus ();

    chain_score_select #(.DW(DW), .IW(IW), .MAX_PRED(MAX_PRED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    acc_cyc = 0;
    beat_t beats[$];
    res_t  exp_q[$];
    logic  prev_valid = 1'b0;
    logic  prev_hs    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic add(input logic [DW-1:0] f, input logic [DW-1:0] s,
                       input logic [IW-1:0] j, input logic skip);
        beats.push_back(beat_t'{f: f, s: s, j: j, skip: skip});
    endtask

    // Reference reduction over the pending beat list.
    function automatic res_t model(input logic [DW-1:0] w);
        res_t   r;
        longint sum;
        logic [DW-1:0] c;
        r.f = w; r.idx = '0; r.none = 1'b1; r.cnt = '0;
        foreach (beats[k]) begin
            if (!beats[k].skip) begin
                sum = longint'($signed(beats[k].f)) + longint'($signed(beats[k].s));
                if (sum > SMAX)      c = SMAX[DW-1:0];
                else if (sum < SMIN) c = SMIN[DW-1:0];
                else                 c = sum[DW-1:0];
                if (r.cnt != {IW{1'b1}}) r.cnt = r.cnt + IW'(1);
                if ($signed(c) > $signed(r.f)) begin
                    r.f = c; r.idx = beats[k].j; r.none = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Drive one beat (inputs change 1 time unit after posedge) and hold until accepted.
    task automatic send_beat(input beat_t b, input logic [DW-1:0] w, input logic last);
        logic rdy;
        int   n;
        bus.s_valid    = 1'b1;
        bus.s_pred_f   = b.f;
        bus.s_score    = b.s;
        bus.s_pred_idx = b.j;
        bus.s_skip     = b.skip;
        bus.s_last     = last;
        bus.s_anchor_w = w;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = bus.s_ready;
            if (rdy) acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) chk("s_ready_timeout", 64'd0, 64'd1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic run_anchor(input logic [DW-1:0] w, input res_t e);
        exp_q.push_back(e);
        foreach (beats[k]) send_beat(beats[k], w, (k == beats.size() - 1));
        beats.delete();
    endtask

    task automatic run_model_anchor(input logic [DW-1:0] w);
        run_anchor(w, model(w));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Result monitor: samples on the falling edge, away from input changes.
    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) chk("m_valid_drop", bus.m_valid, 1'b0);
            if (bus.m_valid && !prev_valid) chk("latency", cyc - acc_cyc, 1);
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_f",         bus.m_f,         e.f);
                    chk("m_pred_idx",  bus.m_pred_idx,  e.idx);
                    chk("m_pred_none", bus.m_pred_none, e.none);
                    chk("m_pred_cnt",  bus.m_pred_cnt,  e.cnt);
                end
            end
            prev_hs    = bus.m_valid && bus.m_ready;
            prev_valid = bus.m_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t hold;
        int   c0;
        int   len;
        reset          = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_score    = '0;
        bus.s_pred_f   = '0;
        bus.s_pred_idx = '0;
        bus.s_skip     = 1'b0;
        bus.s_last     = 1'b0;
        bus.s_anchor_w = '0;
        bus.m_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_s_ready",  bus.s_ready,      1'b1);
        chk("rst_m_valid",  bus.m_valid,      1'b0);
        chk("rst_m_f",      bus.m_f,          0);
        chk("rst_m_idx",    bus.m_pred_idx,   0);
        chk("rst_m_cnt",    bus.m_pred_cnt,   0);
        chk("rst_m_none",   bus.m_pred_none,  1'b1);
        chk("rst_err",      bus.err_overflow, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Two beats, first one wins.
        add(32'd100, -32'sd20, 16'd3, 1'b0);
        add(32'd50,  32'd10,   16'd5, 1'b0);
        run_anchor(32'd40, res_t'{f: 32'd80, idx: 16'd3, none: 1'b0, cnt: 16'd2});

        // Single beat below W_i.
        add(32'd10, 32'd5, 16'd1, 1'b0);
        run_anchor(32'd40, res_t'{f: 32'd40, idx: 16'd0, none: 1'b1, cnt: 16'd1});

        // Ties with W_i never win.
        add(32'd30, 32'd10, 16'd2, 1'b0);
        add(32'd20, 32'd20, 16'd7, 1'b0);
        run_anchor(32'd40, res_t'{f: 32'd40, idx: 16'd0, none: 1'b1, cnt: 16'd2});

        // Positive saturation.
        add(32'h7FFF_FFF0, 32'h0000_0100, 16'd4, 1'b0);
        run_anchor(32'd0, res_t'{f: 32'h7FFF_FFFF, idx: 16'd4, none: 1'b0, cnt: 16'd1});

        // Negative saturation lands exactly on W_i = most negative: tie, no winner.
        add(32'h8000_0010, -32'sh100, 16'd6, 1'b0);
        run_anchor(32'h8000_0000, res_t'{f: 32'h8000_0000, idx: 16'd0, none: 1'b1, cnt: 16'd1});

        // Skip-only anchor; the skipped beat would otherwise win.
        add(32'd1000, 32'd0, 16'd8, 1'b1);
        run_anchor(32'd9, res_t'{f: 32'd9, idx: 16'd0, none: 1'b1, cnt: 16'd0});

        // Skip in the middle of an anchor does not count or compete.
        add(32'd5,    32'd5, 16'd1, 1'b0);
        add(32'd9000, 32'd0, 16'd2, 1'b1);
        add(32'd6,    32'd5, 16'd3, 1'b0);
        run_anchor(32'd0, res_t'{f: 32'd11, idx: 16'd3, none: 1'b0, cnt: 16'd2});
        drain("drain_directed");

        // Randomised anchors against the reference model.
        for (int a = 0; a < 8; a++) begin
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                add((a < 2) ? 32'h7FFF_0000 + $urandom_range(0, 32'hFFFF) : $urandom,
                    (a < 2) ? 32'h0001_0000 : $urandom,
                    IW'($urandom_range(1, 1000)),
                    ($urandom_range(0, 3) == 0));
            end
            run_model_anchor($urandom);
        end
        drain("drain_random");

        // Backpressure: result held for 5 cycles, next anchor's beat waiting.
        bus.m_ready = 1'b0;
        add(32'd70, 32'd1, 16'd12, 1'b0);
        run_anchor(32'd3, res_t'{f: 32'd71, idx: 16'd12, none: 1'b0, cnt: 16'd1});
        hold = exp_q[0];
        bus.s_valid    = 1'b1;
        bus.s_pred_f   = 32'd1;
        bus.s_score    = 32'd1;
        bus.s_pred_idx = 16'd9;
        bus.s_skip     = 1'b0;
        bus.s_last     = 1'b1;
        bus.s_anchor_w = 32'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_m_valid", bus.m_valid,    1'b1);
            chk("bp_s_ready", bus.s_ready,    1'b0);
            chk("bp_m_f",     bus.m_f,        hold.f);
            chk("bp_m_idx",   bus.m_pred_idx, hold.idx);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        c0 = cyc;
        add(32'd1, 32'd1, 16'd9, 1'b0);
        run_anchor(32'd7, res_t'{f: 32'd7, idx: 16'd0, none: 1'b1, cnt: 16'd1});
        chk("bp_accept_delay", acc_cyc - c0, 1);
        drain("drain_bp");

        // Exactly MAX_PRED beats: no overflow.
        for (int k = 0; k < MAX_PRED; k++) add(DW'(k), 32'd0, IW'(k), 1'b0);
        run_model_anchor(32'd0);
        drain("drain_64");
        chk("err_at_max", bus.err_overflow, 1'b0);

        // MAX_PRED+1 beats: overflow flagged, result still reduced.
        for (int k = 0; k <= MAX_PRED; k++) add(DW'(k), 32'd0, IW'(k), 1'b0);
        run_anchor(32'd0, res_t'{f: 32'd64, idx: 16'd64, none: 1'b0, cnt: 16'd65});
        @(negedge clk);
        chk("err_set", bus.err_overflow, 1'b1);
        drain("drain_65");

        // Sticky across a following normal anchor.
        add(32'd2, 32'd2, 16'd2, 1'b0);
        run_anchor(32'd1, res_t'{f: 32'd4, idx: 16'd2, none: 1'b0, cnt: 16'd1});
        drain("drain_sticky");
        chk("err_sticky", bus.err_overflow, 1'b1);

        // Reset in the middle of an anchor discards everything.
        add(32'd500, 32'd0, 16'd3, 1'b0);
        send_beat(beats[0], 32'd0, 1'b0);
        beats.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_s_ready", bus.s_ready,      1'b1);
        chk("mid_rst_m_valid", bus.m_valid,      1'b0);
        chk("mid_rst_err",     bus.err_overflow, 1'b0);
        chk("mid_rst_m_f",     bus.m_f,          0);
        chk("mid_rst_none",    bus.m_pred_none,  1'b1);
        @(posedge clk);
        #1;

        // First anchor after reset starts clean.
        add(32'd100, -32'sd20, 16'd3, 1'b0);
        add(32'd50,  32'd10,   16'd5, 1'b0);
        run_anchor(32'd40, res_t'{f: 32'd80, idx: 16'd3, none: 1'b0, cnt: 16'd2});
        drain("drain_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
